// File: rtl/controle_acesso_fun_pkg.sv
// Shared definitions for the function access controller: profile codes,
// profile indices, FSM state constants and reset permission masks.
package controle_acesso_fun_pkg;

  localparam logic [2:0] PERFIL_ADM    = 3'b101;
  localparam logic [2:0] PERFIL_USER   = 3'b001;
  localparam logic [2:0] PERFIL_TESTER = 3'b011;
  localparam logic [2:0] PERFIL_GUEST  = 3'b110;
  localparam logic [2:0] PERFIL_AUTO   = 3'b000;

  localparam int NUM_PERFIS = 5;

  typedef enum logic [2:0] {
    IDX_ADM    = 3'd0,
    IDX_USER   = 3'd1,
    IDX_TESTER = 3'd2,
    IDX_GUEST  = 3'd3,
    IDX_AUTO   = 3'd4
  } perfil_idx_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_LOCK  = 2'd3;

  // Bit i-1 enables function i; wider NUM_FUN simply takes more low bits.
  localparam logic [31:0] MASK_ADM_RST    = 32'hFFFF_FFFF;
  localparam logic [31:0] MASK_USER_RST   = 32'h0000_002D;
  localparam logic [31:0] MASK_TESTER_RST = 32'h0000_002F;
  localparam logic [31:0] MASK_GUEST_RST  = 32'h0000_0021;
  localparam logic [31:0] MASK_AUTO_RST   = 32'h0000_0000;

  function automatic logic [31:0] mask_default(input int idx);
    logic [31:0] m;
    case (idx)
      0:       m = MASK_ADM_RST;
      1:       m = MASK_USER_RST;
      2:       m = MASK_TESTER_RST;
      3:       m = MASK_GUEST_RST;
      default: m = MASK_AUTO_RST;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/controle_acesso_fun_decodificador_perfil.sv
// Combinational 3-bit profile code decoder: table index plus a valid flag.
module decodificador_perfil
  import controle_acesso_fun_pkg::*;
(
  input  logic [2:0]  codigo,
  output perfil_idx_t idx,
  output logic        valido
);

  always_comb begin
    idx    = IDX_AUTO;
    valido = 1'b1;
    case (codigo)
      PERFIL_ADM:    idx = IDX_ADM;
      PERFIL_USER:   idx = IDX_USER;
      PERFIL_TESTER: idx = IDX_TESTER;
      PERFIL_GUEST:  idx = IDX_GUEST;
      PERFIL_AUTO:   idx = IDX_AUTO;
      default:       valido = 1'b0;
    endcase
  end

endmodule

// File: rtl/controle_acesso_fun.sv
// Per-profile function access controller with request/response handshakes,
// reprogrammable permission masks and lockout after repeated denials.
module controle_acesso_fun
  import controle_acesso_fun_pkg::*;
#(
  parameter int NUM_FUN     = 7,
  parameter int FUN_W       = 3,
  parameter int MAX_FALHAS  = 3,
  parameter int LOCK_CICLOS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_perfil,
  input  logic [FUN_W-1:0]   req_fun,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_ok,
  output logic [FUN_W-1:0]   resp_fun,
  output logic               bloqueado,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_perfil,
  input  logic [NUM_FUN-1:0] cfg_mask
);

  localparam int CNT_W = $clog2(MAX_FALHAS + 1);
  localparam int TMR_W = $clog2(LOCK_CICLOS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_FALHAS);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_CICLOS);

  logic [1:0]         state_reg, state_next;
  logic [2:0]         perfil_reg;
  logic [FUN_W-1:0]   fun_reg;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [TMR_W-1:0]   timer_reg, timer_next;
  logic               ok_reg, ok_next;
  logic [FUN_W-1:0]   fun_resp_reg, fun_resp_next;
  logic [NUM_FUN-1:0] mask_reg [NUM_PERFIS];

  perfil_idx_t        req_idx, cfg_idx;
  logic               req_valido, cfg_valido;
  logic [NUM_FUN-1:0] mask_sel;
  logic               mask_bit;
  logic               grant;
  logic               captura;

  decodificador_perfil u_dec_req (
    .codigo (perfil_reg),
    .idx    (req_idx),
    .valido (req_valido)
  );

  decodificador_perfil u_dec_cfg (
    .codigo (cfg_perfil),
    .idx    (cfg_idx),
    .valido (cfg_valido)
  );

  // Grant reads the registered masks, so a cfg write landing on the CHECK
  // edge only becomes visible to the following evaluation.
  always_comb begin
    mask_sel = mask_reg[req_idx];
    mask_bit = 1'b0;
    for (int i = 0; i < NUM_FUN; i++) begin
      if (int'(fun_reg) == i + 1) mask_bit = mask_sel[i];
    end
    grant = req_valido && mask_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PERFIS; p++) begin
        mask_reg[p] <= NUM_FUN'(mask_default(p));
      end
    end else if (cfg_we && cfg_valido) begin
      for (int p = 0; p < NUM_PERFIS; p++) begin
        if (int'(cfg_idx) == p) mask_reg[p] <= cfg_mask;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    timer_next    = timer_reg;
    ok_next       = ok_reg;
    fun_resp_next = fun_resp_reg;
    captura       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          captura    = 1'b1;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        ok_next       = grant;
        fun_resp_next = grant ? fun_reg : '0;
        if (grant) begin
          cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          if (cnt_reg == CNT_MAX) begin
            state_next = ST_LOCK;
            timer_next = TMR_LOAD;
            cnt_next   = '0;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_LOCK: begin
        timer_next = (timer_reg != '0) ? timer_reg - 1'b1 : '0;
        if (timer_reg <= TMR_W'(1)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      timer_reg    <= '0;
      ok_reg       <= 1'b0;
      fun_resp_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      timer_reg    <= timer_next;
      ok_reg       <= ok_next;
      fun_resp_reg <= fun_resp_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfil_reg <= '0;
      fun_reg    <= '0;
    end else if (captura) begin
      perfil_reg <= req_perfil;
      fun_reg    <= req_fun;
    end
  end

  assign req_ready  = (state_reg == ST_IDLE);
  assign bloqueado  = (state_reg == ST_LOCK);
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_ok    = (state_reg == ST_RESP) && ok_reg;
  assign resp_fun   = (state_reg == ST_RESP) ? fun_resp_reg : '0;

endmodule

// File: tb/tb_controle_acesso_fun.sv
// Self-checking bench for controle_acesso_fun: directed table, hand-written
// corner sequences and randomized traffic against a permission-set model.
module tb_controle_acesso_fun;

  localparam int NUM_FUN     = 7;
  localparam int FUN_W       = 3;
  localparam int MAX_FALHAS  = 3;
  localparam int LOCK_CICLOS = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [2:0]         req_perfil = '0;
  logic [FUN_W-1:0]   req_fun = '0;
  logic               resp_valid;
  logic               resp_ready = 1'b0;
  logic               resp_ok;
  logic [FUN_W-1:0]   resp_fun;
  logic               bloqueado;
  logic               cfg_we = 1'b0;
  logic [2:0]         cfg_perfil = '0;
  logic [NUM_FUN-1:0] cfg_mask = '0;

  always #5 clk = ~clk;

  controle_acesso_fun #(
    .NUM_FUN(NUM_FUN), .FUN_W(FUN_W), .MAX_FALHAS(MAX_FALHAS), .LOCK_CICLOS(LOCK_CICLOS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_perfil(req_perfil), .req_fun(req_fun),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ok(resp_ok), .resp_fun(resp_fun),
    .bloqueado(bloqueado),
    .cfg_we(cfg_we), .cfg_perfil(cfg_perfil), .cfg_mask(cfg_mask)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: permission sets indexed directly by the raw profile code.
  bit [NUM_FUN-1:0] model_mask [8];
  bit               model_valid [8];
  int               model_falhas;
  bit               skip_lock_wait = 1'b0;

  typedef struct {
    logic [2:0]       perfil;
    logic [FUN_W-1:0] fun;
    bit               ok;
    logic [FUN_W-1:0] fun_exp;
    int               hold;
  } vetor_t;
  vetor_t tabela [13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Decimal digits name the enabled functions, e.g. 1346 -> {1,3,4,6}.
  function automatic bit [NUM_FUN-1:0] lista(input int digitos);
    bit [NUM_FUN-1:0] m = '0;
    int d = digitos;
    while (d > 0) begin
      m[(d % 10) - 1] = 1'b1;
      d = d / 10;
    end
    return m;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 8; c++) begin
      model_mask[c]  = '0;
      model_valid[c] = 1'b0;
    end
    model_valid[5] = 1'b1; model_mask[5] = lista(1234567);
    model_valid[1] = 1'b1; model_mask[1] = lista(1346);
    model_valid[3] = 1'b1; model_mask[3] = lista(12346);
    model_valid[6] = 1'b1; model_mask[6] = lista(16);
    model_valid[0] = 1'b1; model_mask[0] = lista(0);
    model_falhas = 0;
  endfunction

  function automatic bit model_grant(input logic [2:0] p, input logic [FUN_W-1:0] f);
    if (!model_valid[p]) return 1'b0;
    if (f < 1 || int'(f) > NUM_FUN) return 1'b0;
    return model_mask[p][int'(f) - 1];
  endfunction

  function automatic void model_cfg(input logic [2:0] p, input logic [NUM_FUN-1:0] m);
    if (model_valid[p]) model_mask[p] = m;
  endfunction

  // Starts and ends at a falling edge (unless a lock is left pending).
  task automatic transact(input string nm, input logic [2:0] p, input logic [FUN_W-1:0] f,
                          input int hold, input bit exp_ok, input logic [FUN_W-1:0] exp_fun,
                          input bit cfg_em_check, input logic [2:0] cp,
                          input logic [NUM_FUN-1:0] cm);
    int n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s.wait_ready actual=%0b required=1", nm, req_ready);
      return;
    end
    req_valid = 1'b1; req_perfil = p; req_fun = f;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (cfg_em_check) begin
      cfg_we = 1'b1; cfg_perfil = cp; cfg_mask = cm;
    end
    @(negedge clk);
    check({nm, ".check_resp_valid"}, resp_valid, 0);
    check({nm, ".check_req_ready"}, req_ready, 0);
    @(posedge clk); #1;
    if (cfg_em_check) begin
      cfg_we = 1'b0;
      model_cfg(cp, cm);
    end
    @(negedge clk);
    check({nm, ".resp_valid"}, resp_valid, 1);
    check({nm, ".resp_ok"}, resp_ok, exp_ok);
    check({nm, ".resp_fun"}, resp_fun, exp_fun);
    repeat (hold) begin
      @(negedge clk);
      check({nm, ".hold_valid"}, resp_valid, 1);
      check({nm, ".hold_ok"}, resp_ok, exp_ok);
      check({nm, ".hold_fun"}, resp_fun, exp_fun);
      check({nm, ".hold_req_ready"}, req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({nm, ".resp_done"}, resp_valid, 0);
    if (exp_ok) model_falhas = 0;
    else if (model_falhas < MAX_FALHAS) model_falhas++;
    if (model_falhas == MAX_FALHAS) begin
      model_falhas = 0;
      if (!skip_lock_wait) begin
        @(negedge clk);
        n = 0;
        while (bloqueado === 1'b1 && n < 100) begin
          check({nm, ".lock_req_ready"}, req_ready, 0);
          n++;
          @(negedge clk);
        end
        check({nm, ".lock_cycles"}, n, LOCK_CICLOS);
        check({nm, ".post_lock_ready"}, req_ready, 1);
      end
    end else begin
      @(negedge clk);
      check({nm, ".no_lock"}, bloqueado, 0);
      check({nm, ".idle_ready"}, req_ready, 1);
    end
    $display("txn %s perfil=%b fun=%0d hold=%0d ok=%0b fun_resp=%0d", nm, p, f, hold, exp_ok, exp_fun);
  endtask

  task automatic cfg_write(input logic [2:0] p, input logic [NUM_FUN-1:0] m);
    cfg_we = 1'b1; cfg_perfil = p; cfg_mask = m;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_cfg(p, m);
    @(negedge clk);
    $display("cfg perfil=%b mask=%b", p, m);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]       rp;
    logic [FUN_W-1:0] rf;
    bit               rg;

    tabela[0]  = '{3'b001, 3'd3, 1'b1, 3'd3, 0};
    tabela[1]  = '{3'b110, 3'd2, 1'b0, 3'd0, 0};
    tabela[2]  = '{3'b101, 3'd7, 1'b1, 3'd7, 1};
    tabela[3]  = '{3'b011, 3'd2, 1'b1, 3'd2, 0};
    tabela[4]  = '{3'b001, 3'd2, 1'b0, 3'd0, 2};
    tabela[5]  = '{3'b101, 3'd0, 1'b0, 3'd0, 0};
    tabela[6]  = '{3'b011, 3'd6, 1'b1, 3'd6, 0};
    tabela[7]  = '{3'b110, 3'd6, 1'b1, 3'd6, 0};
    tabela[8]  = '{3'b100, 3'd1, 1'b0, 3'd0, 0};
    tabela[9]  = '{3'b110, 3'd1, 1'b1, 3'd1, 0};
    tabela[10] = '{3'b000, 3'd1, 1'b0, 3'd0, 0};
    tabela[11] = '{3'b111, 3'd1, 1'b0, 3'd0, 0};
    tabela[12] = '{3'b001, 3'd0, 1'b0, 3'd0, 0};

    model_reset();
    repeat (3) @(negedge clk);
    check("reset.resp_valid", resp_valid, 0);
    check("reset.resp_ok", resp_ok, 0);
    check("reset.resp_fun", resp_fun, 0);
    check("reset.bloqueado", bloqueado, 0);
    rst_n = 1'b1;
    #1;
    check("reset.first_ready", req_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      transact($sformatf("tab%0d", i), tabela[i].perfil, tabela[i].fun, tabela[i].hold,
               tabela[i].ok, tabela[i].fun_exp, 1'b0, 3'b0, '0);
    end

    transact("hold5", 3'b001, 3'd4, 5, 1'b1, 3'd4, 1'b0, 3'b0, '0);
    transact("cfg_in_check", 3'b110, 3'd2, 0, 1'b0, 3'd0, 1'b1, 3'b110, 7'b0000010);
    transact("cfg_after", 3'b110, 3'd2, 0, 1'b1, 3'd2, 1'b0, 3'b0, '0);
    cfg_write(3'b111, 7'h7F);
    transact("cfg_invalid", 3'b111, 3'd1, 0, 1'b0, 3'd0, 1'b0, 3'b0, '0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) cfg_write(3'($urandom_range(0, 7)), 7'($urandom));
      rp = 3'($urandom_range(0, 7));
      rf = 3'($urandom_range(0, 7));
      rg = model_grant(rp, rf);
      if ($urandom_range(0, 4) == 0)
        transact($sformatf("rnd%0d", i), rp, rf, $urandom_range(0, 2), rg, rg ? rf : 3'd0,
                 1'b1, 3'($urandom_range(0, 7)), 7'($urandom));
      else
        transact($sformatf("rnd%0d", i), rp, rf, $urandom_range(0, 2), rg, rg ? rf : 3'd0,
                 1'b0, 3'b0, '0);
    end

    // Reset in the middle of a lockout restores default masks.
    cfg_write(3'b110, 7'h7F);
    cfg_write(3'b000, 7'h00);
    transact("pre_clear", 3'b101, 3'd1, 0, 1'b1, 3'd1, 1'b0, 3'b0, '0);
    transact("guest2_open", 3'b110, 3'd2, 0, 1'b1, 3'd2, 1'b0, 3'b0, '0);
    transact("den1", 3'b000, 3'd1, 0, 1'b0, 3'd0, 1'b0, 3'b0, '0);
    transact("den2", 3'b111, 3'd1, 0, 1'b0, 3'd0, 1'b0, 3'b0, '0);
    skip_lock_wait = 1'b1;
    transact("den3", 3'b001, 3'd0, 0, 1'b0, 3'd0, 1'b0, 3'b0, '0);
    skip_lock_wait = 1'b0;
    @(negedge clk);
    check("midlock.bloqueado", bloqueado, 1);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.bloqueado", bloqueado, 0);
    check("async_rst.resp_valid", resp_valid, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release.ready", req_ready, 1);
    @(negedge clk);
    transact("guest2_default", 3'b110, 3'd2, 0, 1'b0, 3'd0, 1'b0, 3'b0, '0);
    transact("guest6_default", 3'b110, 3'd6, 0, 1'b1, 3'd6, 1'b0, 3'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
